alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (>=4).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 op  input  3  000 add, 001 sub, 010 and, 011 or, 100 slt, 101 mul, 110 div, 111 xor.
REQ-007 sign_mode  input  1  1 = signed two's-complement semantics, 0 = unsigned.
REQ-008 a, b  input  WIDTH each  operands.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  WIDTH  primary result (sum, difference, logic, slt, low product, quotient).
REQ-012 upper  output  WIDTH  high product (mul), remainder (div), else 0.
REQ-013 zero, carry, overflow, negative, div_zero  output  1 each  status flags.

Function
REQ-014 FSM states IDLE, BUSY, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 Accept = in_valid && in_ready at a rising edge; op, sign_mode, a, b captured at accept; later input changes ignored.
REQ-016 Non-div ops and div with b==0: IDLE->DONE; out_valid high in the cycle after the accept edge (latency 1).
REQ-017 div with b!=0: IDLE->BUSY; iterative restoring divider, one quotient bit per cycle, WIDTH cycles in BUSY, then DONE; out_valid high WIDTH+1 cycles after accept.
REQ-018 DONE->IDLE on edge where out_ready=1; result, upper, flags held stable while out_valid=1 && out_ready=0.
REQ-019 add/sub: WIDTH-bit wrap-around; carry = carry-out (add) or borrow, i.e. a<b unsigned (sub).
REQ-020 overflow add/sub: signed overflow when sign_mode=1, else 0.
REQ-021 slt: result=1 if a<b (signed when sign_mode=1, unsigned otherwise), else 0.
REQ-022 mul: full 2*WIDTH product, signed or unsigned per sign_mode; low half -> result, high half -> upper.
REQ-023 mul overflow: signed: upper != sign-extension of result[WIDTH-1]; unsigned: upper != 0.
REQ-024 div: quotient truncates toward zero; remainder takes dividend's sign (signed); computed on magnitudes with post-correction.
REQ-025 div b==0: result all ones, upper=a, div_zero=1, no BUSY cycles.
REQ-026 signed div of most-negative by -1: result=most-negative, upper=0, overflow=1.
REQ-027 zero=(result==0) and negative=result[WIDTH-1] for every op.
REQ-028 Every flag not defined for the current op is 0; no flag carries over between operations.
REQ-029 in_valid high during BUSY or DONE is not accepted and does not disturb the operation.

Reset
REQ-030 rst=1 at an edge: state IDLE, out_valid=0, in_ready=1 next cycle, result/upper/all flags=0, iteration counter=0.
REQ-031 rst during BUSY or DONE aborts the operation; no out_valid is ever produced for it.
REQ-032 rst has priority over accept and out_ready at the same edge.

Structure
REQ-033 Shared package alu_pkg holds: op encoding enum (3 bits), ALU_OP_W constant, flag bundle struct, FSM state enum.
REQ-034 Iterative divider is a sub-module alu_divider (start/done handshake, WIDTH parameter, signed correction inside).
REQ-035 Multiplier remains a single-cycle combinational product registered in alu_mc.

Verification (WIDTH=32)
REQ-036 add signed 0x7FFFFFFF+0x1 -> result 0x80000000, overflow=1, negative=1, carry=0, out_valid 1 cycle after accept.
REQ-037 sub unsigned 3-5 -> result 0xFFFFFFFE, carry=1, overflow=0; slt signed 0xFFFFFFFF<1 -> 1, unsigned -> 0.
REQ-038 mul signed -3*7 -> result 0xFFFFFFEB, upper 0xFFFFFFFF, overflow=0; unsigned 0xFFFFFFFF*2 -> result 0xFFFFFFFE, upper 0x1, overflow=1.
REQ-039 div signed -7/2 -> result 0xFFFFFFFD, upper 0xFFFFFFFF, out_valid exactly 33 cycles after accept; 100/0 -> result 0xFFFFFFFF, upper 100, div_zero=1, 1-cycle latency.
REQ-040 out_ready low 5 cycles after out_valid -> outputs unchanged, in_ready=0, in_valid pulses ignored; out_ready=1 -> in_ready=1 next cycle.
REQ-041 rst asserted 10 cycles into a division -> next cycle IDLE, in_ready=1, out_valid=0, all outputs 0; subsequent add 2+2 returns 4.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: op encoding, flag bundle
// and FSM states.
package alu_pkg;

   localparam int ALU_OP_W = 3;

   typedef enum logic [ALU_OP_W-1:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_SLT = 3'b100,
      OP_MUL = 3'b101,
      OP_DIV = 3'b110,
      OP_XOR = 3'b111
   } alu_op_e;

   typedef struct packed {
      logic zero;
      logic carry;
      logic overflow;
      logic negative;
      logic div_zero;
   } alu_flags_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } alu_state_e;

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle of the multi-cycle ALU; master drives
// requests, slave is the ALU.
interface alu_mc_if #(
   parameter int WIDTH = 32
);
   import alu_pkg::*;

   logic                in_valid;
   logic                in_ready;
   logic [ALU_OP_W-1:0] op;
   logic                sign_mode;
   logic [WIDTH-1:0]    a;
   logic [WIDTH-1:0]    b;
   logic                out_valid;
   logic                out_ready;
   logic [WIDTH-1:0]    result;
   logic [WIDTH-1:0]    upper;
   logic                zero;
   logic                carry;
   logic                overflow;
   logic                negative;
   logic                div_zero;

   modport master (
      output in_valid, op, sign_mode, a, b, out_ready,
      input  in_ready, out_valid, result, upper,
      input  zero, carry, overflow, negative, div_zero
   );

   modport slave (
      input  in_valid, op, sign_mode, a, b, out_ready,
      output in_ready, out_valid, result, upper,
      output zero, carry, overflow, negative, div_zero
   );

endinterface

// File: rtl/alu_divider.sv
// Restoring divider on operand magnitudes, one quotient bit per cycle;
// signs are reapplied to quotient/remainder at the output.
module alu_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sign_mode,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             overflow
);
   localparam int CW  = $clog2(WIDTH + 1);
   localparam int MSB = WIDTH - 1;

   logic             busy_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
   logic             neg_quo_q, neg_rem_q, ovf_q;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic [2*WIDTH-1:0] first, next;

   function automatic logic [2*WIDTH-1:0] step(
      input logic [WIDTH-1:0] rem,
      input logic [WIDTH-1:0] quo,
      input logic [WIDTH-1:0] dvs
   );
      logic [WIDTH:0] sh;
      logic [WIDTH:0] tr;
      sh = {rem, quo[MSB]};
      tr = sh - {1'b0, dvs};
      if (tr[WIDTH])
         return {sh[MSB:0], quo[MSB-1:0], 1'b0};
      return {tr[MSB:0], quo[MSB-1:0], 1'b1};
   endfunction

   assign mag_a = (sign_mode && dividend[MSB]) ? -dividend : dividend;
   assign mag_b = (sign_mode && divisor[MSB]) ? -divisor : divisor;

   // The start edge already performs the first iteration.
   assign first = step('0, mag_a, mag_b);
   assign next  = step(rem_q, quo_q, dvs_q);

   assign done      = busy_q && (cnt_q == CW'(WIDTH));
   assign quotient  = neg_quo_q ? -quo_q : quo_q;
   assign remainder = neg_rem_q ? -rem_q : rem_q;
   assign overflow  = ovf_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q    <= 1'b0;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else if (start) begin
         busy_q         <= 1'b1;
         cnt_q          <= CW'(1);
         {rem_q, quo_q} <= first;
         dvs_q          <= mag_b;
         neg_quo_q      <= sign_mode & (dividend[MSB] ^ divisor[MSB]);
         neg_rem_q      <= sign_mode & dividend[MSB];
         ovf_q          <= sign_mode
                           && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                           && (divisor == '1);
      end else if (done) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
      end else if (busy_q) begin
         {rem_q, quo_q} <= next;
         cnt_q          <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle add/sub/logic/slt/mul, iterative
// divide, valid/ready on both request and result sides.
module alu_mc #(
   parameter int WIDTH = 32
) (
   input  logic     clk,
   input  logic     rst,
   alu_mc_if.slave  bus
);
   import alu_pkg::*;

   localparam int MSB = WIDTH - 1;

   alu_state_e state_q, state_d;
   alu_op_e    op_e;
   alu_flags_t fl_q, fl_d, div_fl;

   logic             accept, div_go, div_done, div_ovf, sm, slt;
   logic [WIDTH-1:0] a, b, res_q, up_q, res_d, up_d, div_q, div_r;
   logic [WIDTH:0]   sum, diff;
   logic [2*WIDTH-1:0] ext_a, ext_b, prod;

   assign op_e = alu_op_e'(bus.op);
   assign sm   = bus.sign_mode;
   assign a    = bus.a;
   assign b    = bus.b;

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign accept        = bus.in_valid && bus.in_ready;
   assign div_go        = accept && (op_e == OP_DIV) && (b != '0);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (accept) state_d = div_go ? S_BUSY : S_DONE;
         S_BUSY: if (div_done) state_d = S_DONE;
         S_DONE: if (bus.out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      sum   = {1'b0, a} + {1'b0, b};
      diff  = {1'b0, a} - {1'b0, b};
      ext_a = sm ? {{WIDTH{a[MSB]}}, a} : {{WIDTH{1'b0}}, a};
      ext_b = sm ? {{WIDTH{b[MSB]}}, b} : {{WIDTH{1'b0}}, b};
      prod  = ext_a * ext_b;
      slt   = sm ? ($signed(a) < $signed(b)) : (a < b);
      res_d = '0;
      up_d  = '0;
      fl_d  = '0;
      unique case (op_e)
         OP_ADD: begin
            res_d       = sum[MSB:0];
            fl_d.carry  = sum[WIDTH];
            fl_d.overflow = sm & (a[MSB] == b[MSB]) & (sum[MSB] != a[MSB]);
         end
         OP_SUB: begin
            res_d       = diff[MSB:0];
            fl_d.carry  = diff[WIDTH];
            fl_d.overflow = sm & (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]);
         end
         OP_AND: res_d = a & b;
         OP_OR:  res_d = a | b;
         OP_XOR: res_d = a ^ b;
         OP_SLT: res_d = {{(WIDTH-1){1'b0}}, slt};
         OP_MUL: begin
            res_d = prod[MSB:0];
            up_d  = prod[2*WIDTH-1:WIDTH];
            fl_d.overflow = sm ? (up_d != {WIDTH{prod[MSB]}})
                               : (up_d != '0);
         end
         // Only the divide-by-zero case resolves here.
         OP_DIV: begin
            res_d         = '1;
            up_d          = a;
            fl_d.div_zero = 1'b1;
         end
         default: res_d = '0;
      endcase
      fl_d.zero     = (res_d == '0);
      fl_d.negative = res_d[MSB];
   end

   always_comb begin
      div_fl          = '0;
      div_fl.zero     = (div_q == '0);
      div_fl.negative = div_q[MSB];
      div_fl.overflow = div_ovf;
   end

   alu_divider #(.WIDTH(WIDTH)) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (div_go),
      .sign_mode (sm),
      .dividend  (a),
      .divisor   (b),
      .done      (div_done),
      .quotient  (div_q),
      .remainder (div_r),
      .overflow  (div_ovf)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         res_q   <= '0;
         up_q    <= '0;
         fl_q    <= '0;
      end else begin
         state_q <= state_d;
         if (accept && !div_go) begin
            res_q <= res_d;
            up_q  <= up_d;
            fl_q  <= fl_d;
         end else if (state_q == S_BUSY && div_done) begin
            res_q <= div_q;
            up_q  <= div_r;
            fl_q  <= div_fl;
         end
      end
   end

   assign bus.result   = res_q;
   assign bus.upper    = up_q;
   assign bus.zero     = fl_q.zero;
   assign bus.carry    = fl_q.carry;
   assign bus.overflow = fl_q.overflow;
   assign bus.negative = fl_q.negative;
   assign bus.div_zero = fl_q.div_zero;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc at WIDTH=32.
module tb_alu_mc;

   typedef struct packed {
      logic [31:0] res;
      logic [31:0] up;
      logic [4:0]  fl;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   exp_t exp_q[$];

   alu_mc_if #(.WIDTH(32)) bus ();

   alu_mc #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [4:0] got_flags();
      return {bus.zero, bus.carry, bus.overflow, bus.negative, bus.div_zero};
   endfunction

   function automatic exp_t model(input logic [2:0] op, input logic sm,
                                  input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      longint      sa, sb, r;
      logic [63:0] p;
      logic [32:0] s;
      logic        c, o, dz;
      e  = '0;
      c  = 1'b0;
      o  = 1'b0;
      dz = 1'b0;
      r  = 0;
      sa = sm ? longint'($signed(a)) : longint'(a);
      sb = sm ? longint'($signed(b)) : longint'(b);
      case (op)
         3'b000: begin
            s = {1'b0, a} + {1'b0, b};
            e.res = s[31:0];
            c = s[32];
            r = sa + sb;
            o = sm && (r != longint'($signed(r[31:0])));
         end
         3'b001: begin
            e.res = a - b;
            c = (a < b);
            r = sa - sb;
            o = sm && (r != longint'($signed(r[31:0])));
         end
         3'b010: e.res = a & b;
         3'b011: e.res = a | b;
         3'b111: e.res = a ^ b;
         3'b100: e.res = (sa < sb) ? 32'd1 : 32'd0;
         3'b101: begin
            if (sm) begin
               r = sa * sb;
               p = r;
               o = (r != longint'($signed(r[31:0])));
            end else begin
               p = {32'b0, a} * {32'b0, b};
               o = (p[63:32] != 32'd0);
            end
            e.res = p[31:0];
            e.up  = p[63:32];
         end
         default: begin
            if (b == 32'd0) begin
               e.res = 32'hFFFF_FFFF;
               e.up  = a;
               dz    = 1'b1;
            end else if (sm && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               e.res = a;
               e.up  = 32'd0;
               o     = 1'b1;
            end else begin
               r     = sa / sb;
               e.res = r[31:0];
               r     = sa % sb;
               e.up  = r[31:0];
            end
         end
      endcase
      e.fl = {(e.res == 32'd0), c, o, e.res[31], dz};
      return e;
   endfunction

   task automatic run_op(input logic [2:0] op, input logic sm,
                         input logic [31:0] a, input logic [31:0] b,
                         input string tag);
      exp_t e;
      int   lat;
      int   exp_lat;
      exp_q.push_back(model(op, sm, a, b));
      exp_lat = (op == 3'b110 && b != 32'd0) ? 33 : 1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s in_ready got=%b want=1", tag, bus.in_ready);
      end
      bus.in_valid  = 1'b1;
      bus.op        = op;
      bus.sign_mode = sm;
      bus.a         = a;
      bus.b         = b;
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.op        = ~op;
      bus.sign_mode = ~sm;
      bus.a         = ~a;
      bus.b         = 32'd5;
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      e = exp_q.pop_front();
      checks++;
      if (lat != exp_lat) begin
         failures++;
         $display("FAIL %s latency got=%0d want=%0d", tag, lat, exp_lat);
      end
      checks++;
      if (bus.result !== e.res) begin
         failures++;
         $display("FAIL %s result got=%h want=%h", tag, bus.result, e.res);
      end
      checks++;
      if (bus.upper !== e.up) begin
         failures++;
         $display("FAIL %s upper got=%h want=%h", tag, bus.upper, e.up);
      end
      checks++;
      if (got_flags() !== e.fl) begin
         failures++;
         $display("FAIL %s flags(z,c,o,n,dz) got=%b want=%b",
                  tag, got_flags(), e.fl);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset handshake got in_ready=%b out_valid=%b want 1/0",
                  bus.in_ready, bus.out_valid);
      end
      checks++;
      if (bus.result !== 32'd0 || bus.upper !== 32'd0 || got_flags() !== 5'd0) begin
         failures++;
         $display("FAIL reset outputs got res=%h up=%h fl=%b want 0",
                  bus.result, bus.upper, got_flags());
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_add_sub_slt();
      run_op(3'b000, 1'b1, 32'h7FFF_FFFF, 32'h1, "add_ovf");
      run_op(3'b000, 1'b0, 32'hFFFF_FFFF, 32'h2, "add_carry");
      run_op(3'b001, 1'b0, 32'd3, 32'd5, "sub_borrow");
      run_op(3'b001, 1'b1, 32'h8000_0000, 32'h1, "sub_ovf");
      run_op(3'b001, 1'b0, 32'd9, 32'd9, "sub_zero");
      run_op(3'b100, 1'b1, 32'hFFFF_FFFF, 32'd1, "slt_signed");
      run_op(3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1, "slt_unsigned");
   endtask

   task automatic test_logic();
      run_op(3'b010, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, "and");
      run_op(3'b011, 1'b1, 32'h8000_0001, 32'h0000_0100, "or");
      run_op(3'b111, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "xor_zero");
   endtask

   task automatic test_mul();
      run_op(3'b101, 1'b1, 32'hFFFF_FFFD, 32'd7, "mul_signed");
      run_op(3'b101, 1'b0, 32'hFFFF_FFFF, 32'd2, "mul_unsigned_ovf");
      run_op(3'b101, 1'b1, 32'h0001_0000, 32'h0001_0000, "mul_signed_ovf");
   endtask

   task automatic test_div();
      run_op(3'b110, 1'b1, 32'hFFFF_FFF9, 32'd2, "div_neg");
      run_op(3'b110, 1'b0, 32'd100, 32'd0, "div_zero");
      run_op(3'b110, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_min");
      run_op(3'b110, 1'b1, 32'd7, 32'hFFFF_FFFE, "div_negdiv");
      run_op(3'b110, 1'b0, 32'hFFFF_FFF9, 32'd2, "div_unsigned");
      run_op(3'b110, 1'b0, 32'd3, 32'd10, "div_small");
   endtask

   task automatic test_backpressure();
      exp_t e;
      int   lat;
      bus.out_ready = 1'b0;
      exp_q.push_back(model(3'b101, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0));
      bus.in_valid  = 1'b1;
      bus.op        = 3'b101;
      bus.sign_mode = 1'b0;
      bus.a         = 32'h1234_5678;
      bus.b         = 32'h9ABC_DEF0;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      e = exp_q.pop_front();
      checks++;
      if (bus.result !== e.res || bus.upper !== e.up) begin
         failures++;
         $display("FAIL bp_first got=%h/%h want=%h/%h",
                  bus.result, bus.upper, e.res, e.up);
      end
      for (int i = 0; i < 5; i++) begin
         bus.in_valid  = (i % 2 == 0);
         bus.op        = 3'b000;
         bus.a         = 32'd1;
         bus.b         = 32'd1;
         @(posedge clk);
         #1;
         checks++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold_hs[%0d] got ov=%b ir=%b want 1/0",
                     i, bus.out_valid, bus.in_ready);
         end
         checks++;
         if (bus.result !== e.res || bus.upper !== e.up || got_flags() !== e.fl) begin
            failures++;
            $display("FAIL bp_hold_data[%0d] got=%h/%h/%b want=%h/%h/%b",
                     i, bus.result, bus.upper, got_flags(), e.res, e.up, e.fl);
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL bp_release got ir=%b ov=%b want 1/0",
                  bus.in_ready, bus.out_valid);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL bp_no_ghost got ov=%b want 0", bus.out_valid);
      end
      run_op(3'b001, 1'b1, 32'd10, 32'd20, "bp_after");
   endtask

   task automatic test_reset_abort();
      int seen;
      bus.in_valid  = 1'b1;
      bus.op        = 3'b110;
      bus.sign_mode = 1'b1;
      bus.a         = 32'hFFFF_FC18;
      bus.b         = 32'd7;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL abort_hs got ir=%b ov=%b want 1/0",
                  bus.in_ready, bus.out_valid);
      end
      checks++;
      if (bus.result !== 32'd0 || bus.upper !== 32'd0 || got_flags() !== 5'd0) begin
         failures++;
         $display("FAIL abort_outputs got=%h/%h/%b want 0",
                  bus.result, bus.upper, got_flags());
      end
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("FAIL abort_no_result got=%0d out_valid cycles want=0", seen);
      end
      run_op(3'b000, 1'b0, 32'd2, 32'd2, "abort_add");
   endtask

   task automatic test_back_to_back();
      logic [2:0]  op;
      logic        sm;
      logic [31:0] a, b;
      for (int i = 0; i < 24; i++) begin
         op = 3'($urandom_range(0, 7));
         sm = 1'($urandom_range(0, 1));
         a  = $urandom;
         b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         run_op(op, sm, a, b, $sformatf("rand%0d_op%0d", i, op));
      end
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.op        = 3'b000;
      bus.sign_mode = 1'b0;
      bus.a         = 32'd0;
      bus.b         = 32'd0;
      bus.out_ready = 1'b1;
      test_reset();
      test_add_sub_slt();
      test_logic();
      test_mul();
      test_div();
      test_backpressure();
      test_reset_abort();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
